// File: rtl/multi_port_ram.sv
// N-port RAM with per-port valid/ready, round-robin collision arbitration and a post-reset clear sweep.
// Optional per-port stall counters are compiled in with MPRAM_STALL_CNT_EN.
module multi_port_ram #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            valid,
  input  logic [NUM_PORTS-1:0]            we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata,
  output logic [NUM_PORTS-1:0]            ready,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] rdata,
  output logic [NUM_PORTS-1:0]            rvalid,
  output logic                            init_done,
  output logic [NUM_PORTS*16-1:0]         stall_cnt
);

  localparam int PW = $clog2(NUM_PORTS);
  localparam logic [ADDR_WIDTH:0]   LIMIT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(DEPTH-1);

  typedef enum logic {INIT, RUN} state_t;

  state_t                 state_reg;
  logic [ADDR_WIDTH-1:0]  init_ptr_reg;
  logic [PW-1:0]          rr_ptr_reg;
  logic [PW-1:0]          rr_ptr_next;
  logic                   any_stall;
  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_WIDTH-1:0]  addr_a [NUM_PORTS];
  logic [DATA_WIDTH-1:0]  wdata_a [NUM_PORTS];
  logic [DATA_WIDTH-1:0]  rdata_reg [NUM_PORTS];
  logic [NUM_PORTS-1:0]   rvalid_reg;
  logic                   init_done_reg;
  logic [NUM_PORTS-1:0]   in_range;
  logic [NUM_PORTS-1:0]   blocked;
  logic [NUM_PORTS-1:0]   involved;
  int                     prio [NUM_PORTS];

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign addr_a[gi]  = addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_a[gi] = wdata[gi*DATA_WIDTH +: DATA_WIDTH];
      assign rdata[gi*DATA_WIDTH +: DATA_WIDTH] = rdata_reg[gi];
      assign in_range[gi] = {1'b0, addr_a[gi]} < LIMIT;
    end
  endgenerate

  assign rvalid    = rvalid_reg;
  assign init_done = init_done_reg;

  // prio 0 is the port at rr_ptr; a port loses only to a conflicting port with smaller prio.
  always_comb begin
    int best;
    int win;
    blocked     = '0;
    involved    = '0;
    rr_ptr_next = rr_ptr_reg;
    best        = NUM_PORTS;
    win         = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      prio[k] = (k + NUM_PORTS - int'(rr_ptr_reg)) % NUM_PORTS;
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (i != j && valid[i] && valid[j] && addr_a[i] == addr_a[j] && (we[i] || we[j])) begin
          involved[i] = 1'b1;
          if (prio[j] < prio[i]) blocked[i] = 1'b1;
        end
      end
    end
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (involved[k] && prio[k] < best) begin
        best = prio[k];
        win  = k;
      end
    end
    if (best < NUM_PORTS) rr_ptr_next = PW'((win + 1) % NUM_PORTS);
    ready     = (state_reg == RUN) ? ~blocked : '0;
    any_stall = |(valid & ~ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= INIT;
      init_ptr_reg  <= '0;
      rr_ptr_reg    <= '0;
      rvalid_reg    <= '0;
      init_done_reg <= 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) rdata_reg[i] <= '0;
    end else begin
      case (state_reg)
        INIT: begin
          init_ptr_reg <= init_ptr_reg + 1'b1;
          if (init_ptr_reg == LAST) begin
            state_reg     <= RUN;
            init_done_reg <= 1'b1;
          end
        end
        RUN: begin
          if (any_stall) rr_ptr_reg <= rr_ptr_next;
          for (int i = 0; i < NUM_PORTS; i++) begin
            rvalid_reg[i] <= valid[i] & ready[i] & ~we[i];
            if (valid[i] && ready[i] && !we[i]) begin
              rdata_reg[i] <= in_range[i] ? mem[addr_a[i]] : '0;
            end
          end
        end
        default: state_reg <= INIT;
      endcase
    end
  end

  // Array storage: cleared by the sweep, then written by accepted in-range writes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_reg == INIT) begin
        mem[init_ptr_reg] <= '0;
      end else begin
        for (int i = 0; i < NUM_PORTS; i++) begin
          if (valid[i] && ready[i] && we[i] && in_range[i]) mem[addr_a[i]] <= wdata_a[i];
        end
      end
    end
  end

`ifdef MPRAM_STALL_CNT_EN
  logic [15:0] stall_cnt_reg [NUM_PORTS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PORTS; i++) stall_cnt_reg[i] <= '0;
    end else if (state_reg == RUN) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (valid[i] && !ready[i] && stall_cnt_reg[i] != 16'hFFFF) begin
          stall_cnt_reg[i] <= stall_cnt_reg[i] + 16'd1;
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_stall
      assign stall_cnt[gi*16 +: 16] = stall_cnt_reg[gi];
    end
  endgenerate
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_multi_port_ram.sv
// Directed plus randomized bench for multi_port_ram against a priority-scan reference model.
module tb_multi_port_ram;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int D  = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    valid = '0;
  logic [N-1:0]    we = '0;
  logic [N*AW-1:0] addr = '0;
  logic [N*DW-1:0] wdata = '0;
  logic [N-1:0]    ready;
  logic [N*DW-1:0] rdata;
  logic [N-1:0]    rvalid;
  logic            init_done;
  logic [N*16-1:0] stall_cnt;

  always #5 clk = ~clk;

  multi_port_ram #(.NUM_PORTS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .valid(valid), .we(we), .addr(addr), .wdata(wdata),
    .ready(ready), .rdata(rdata), .rvalid(rvalid), .init_done(init_done), .stall_cnt(stall_cnt)
  );

  int compared = 0;
  int mismatched = 0;

  // reference model state
  logic [DW-1:0] m_mem [D];
  int            m_rr;
  int            m_stall [N];
  logic [N-1:0]  m_rvalid;
  logic [DW-1:0] m_rdata [N];

  // per-port stimulus
  logic [N-1:0]  d_valid = '0;
  logic [N-1:0]  d_we = '0;
  int            d_addr [N];
  logic [DW-1:0] d_wdata [N];
  logic [N-1:0]  last_acc = '0;
  logic [N-1:0]  dut_acc = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      valid[k] = d_valid[k];
      we[k]    = d_we[k];
      addr[k*AW +: AW]  = AW'(d_addr[k]);
      wdata[k*DW +: DW] = d_wdata[k];
    end
  endtask

  task automatic model_reset();
    for (int a = 0; a < D; a++) m_mem[a] = '0;
    m_rr = 0;
    m_rvalid = '0;
    for (int k = 0; k < N; k++) begin
      m_stall[k] = 0;
      m_rdata[k] = '0;
    end
  endtask

  task automatic check_outputs(input string tag);
    for (int k = 0; k < N; k++) begin
      check($sformatf("%s_rvalid%0d", tag, k), 32'(rvalid[k]), 32'(m_rvalid[k]));
      check($sformatf("%s_rdata%0d", tag, k), 32'(rdata[k*DW +: DW]), 32'(m_rdata[k]));
`ifdef MPRAM_STALL_CNT_EN
      check($sformatf("%s_stall%0d", tag, k), 32'(stall_cnt[k*16 +: 16]), 32'(m_stall[k]));
`else
      check($sformatf("%s_stall%0d", tag, k), 32'(stall_cnt[k*16 +: 16]), 32'd0);
`endif
    end
  endtask

  // One RUN cycle: predict grants by scanning ports in priority order, then apply effects.
  task automatic cycle(input string tag);
    logic [N-1:0] exp_ready;
    int k;
    int j;
    int win;
    drive();
    #1;
    exp_ready = '1;
    win = -1;
    for (int p = 0; p < N; p++) begin
      k = (m_rr + p) % N;
      if (d_valid[k]) begin
        for (int q = 0; q < N; q++) begin
          j = (m_rr + q) % N;
          if (j != k && d_valid[j] && d_addr[j] == d_addr[k] && (d_we[j] || d_we[k])) begin
            if (q < p) exp_ready[k] = 1'b0;
            if (win < 0) win = k;
          end
        end
      end
    end
    for (int i = 0; i < N; i++) check($sformatf("%s_ready%0d", tag, i), 32'(ready[i]), 32'(exp_ready[i]));
    dut_acc  = ready & d_valid;
    last_acc = exp_ready & d_valid;
    if (|(d_valid & ~exp_ready)) m_rr = (win + 1) % N;
    for (int i = 0; i < N; i++) begin
      if (d_valid[i] && !exp_ready[i]) m_stall[i]++;
      m_rvalid[i] = last_acc[i] & ~d_we[i];
      if (m_rvalid[i]) m_rdata[i] = (d_addr[i] < D) ? m_mem[d_addr[i]] : '0;
    end
    for (int i = 0; i < N; i++) begin
      if (last_acc[i] && d_we[i] && d_addr[i] < D) m_mem[d_addr[i]] = d_wdata[i];
    end
    $display("[%0t] %s valid=%b we=%b accepted=%b rr_next=%0d", $time, tag, d_valid, d_we, last_acc, m_rr);
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  // Reset for 2 cycles (current stimulus held during the first), then watch the clear sweep.
  task automatic do_init(input string tag);
    rst = 1'b1;
    drive();
    @(posedge clk);
    #1;
    model_reset();
    check_outputs({tag, "_rst"});
    check({tag, "_rst_ready"}, 32'(ready), 32'd0);
    check({tag, "_rst_done"}, 32'(init_done), 32'd0);
    d_valid = '0;
    drive();
    @(posedge clk);
    #1;
    rst = 1'b0;
    d_valid = '1;
    d_we = '0;
    drive();
    for (int w = 0; w <= 16; w++) begin
      if (w > 0) begin
        @(posedge clk);
        #1;
      end
      check($sformatf("%s_done_w%0d", tag, w), 32'(init_done), 32'(w == 16));
      if (w < 16) check($sformatf("%s_ready_w%0d", tag, w), 32'(ready), 32'd0);
    end
    d_valid = '0;
    drive();
    $display("[%0t] %s init sweep observed", $time, tag);
  endtask

  initial begin
    int grants [N];
    for (int k = 0; k < N; k++) begin
      d_addr[k] = 0;
      d_wdata[k] = '0;
    end

    do_init("init");

    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < N; k++) begin
        d_valid[k] = 1'b1;
        d_we[k] = 1'b0;
        d_addr[k] = c * 4 + k;
      end
      cycle("clear_rd");
    end

    d_valid = 4'b0001; d_we = 4'b0001; d_addr[0] = 3; d_wdata[0] = 8'hA5;
    cycle("lat_wr");
    d_valid = 4'b0100; d_we = 4'b0000; d_addr[2] = 3;
    cycle("lat_rd");
    check("lat_rdata2", 32'(rdata[2*DW +: DW]), 32'h0000_00A5);

    d_valid = 4'b1111; d_we = 4'b0000;
    for (int k = 0; k < N; k++) d_addr[k] = 7;
    cycle("conc_rd");

    d_valid = 4'b1010; d_we = 4'b1010;
    d_addr[1] = 5; d_addr[3] = 5; d_wdata[1] = 8'h11; d_wdata[3] = 8'h33;
    cycle("coll_1");
    d_valid = 4'b1000;
    cycle("coll_2");
    d_valid = 4'b0001; d_we = 4'b0000; d_addr[0] = 5;
    cycle("coll_rd");
    check("coll_mem5", 32'(rdata[DW-1:0]), 32'h0000_0033);

    for (int k = 0; k < N; k++) grants[k] = 0;
    d_valid = 4'b1111; d_we = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < N; k++) begin
        d_addr[k] = 9;
        d_wdata[k] = DW'(8'h90 + c * 4 + k);
      end
      cycle("fair");
      for (int k = 0; k < N; k++) if (dut_acc[k]) grants[k]++;
    end
    for (int k = 0; k < N; k++) check($sformatf("fair_grants%0d", k), 32'(grants[k]), 32'd1);

    d_valid = '0;
    last_acc = '0;
    for (int c = 0; c < 300; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!(d_valid[k] && !last_acc[k])) begin
          d_valid[k] = ($urandom_range(0, 9) < 7);
          d_we[k]    = 1'($urandom_range(0, 1));
          d_addr[k]  = $urandom_range(0, 3);
          d_wdata[k] = DW'($urandom);
        end
      end
      cycle("rand");
    end

    d_valid = 4'b0010; d_we = 4'b0010; d_addr[1] = 5; d_wdata[1] = 8'h77;
    cycle("pre_rst_wr");
    d_valid = 4'b0001; d_we = 4'b0000; d_addr[0] = 5;
    do_init("midrst");
    d_valid = 4'b0001; d_we = 4'b0000; d_addr[0] = 5;
    cycle("post_rst_rd");
    check("post_rst_mem5", 32'(rdata[DW-1:0]), 32'd0);
    d_valid = '0;
    drive();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
